vga_timing_gen: RTL and testbench

Generates 640x480 @ 60 Hz VGA raster timing from the system clock. Produces the pixel coordinates `hc`/`vc` consumed directly by the background, sprite and draw-logic stages, plus the `hsync`/`vsync` pins and an active-video qualifier. It sits upstream of every per-pixel draw block in the game display path.

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_timing_if.sv | 15 +
 rtl/pix_tick_gen.sv | 24 ++
 rtl/vga_timing_gen.sv | 105 ++++++++++
 tb/tb_vga_timing_gen.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants and helpers; draw stages take COORD_W from here.
package vga_timing_pkg;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned COORD_MAX = 1 << COORD_W;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Half-open window test done at 32 bits so a window ending at COORD_MAX cannot wrap.
  function automatic logic in_window(logic [COORD_W-1:0] v, int unsigned lo, int unsigned hi);
    int unsigned vv;
    vv = 32'(v);
    return (vv >= lo) && (vv < hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle from vga_timing_gen to the per-pixel draw stages.
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic [COORD_W-1:0] hc;
  logic [COORD_W-1:0] vc;
  logic               hsync;
  logic               vsync;
  logic               video_on;
  logic               pix_tick;
  logic               frame_start;

  modport master (output hc, vc, hsync, vsync, video_on, pix_tick, frame_start);
  modport slave  (input  hc, vc, hsync, vsync, video_on, pix_tick, frame_start);
endinterface

// File: rtl/pix_tick_gen.sv
// Divides the system clock down to the pixel rate: one pix_tick every CLK_DIV clocks.
module pix_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_tick
);

  localparam int unsigned    DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               div <= '0;
    else if (div == DIV_LAST) div <= '0;
    else                      div <= div + DIV_W'(1);
  end

  // Gated by rst_n so the tick reads 0 during reset even when CLK_DIV=1.
  assign pix_tick = rst_n & (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel coordinates, active-low syncs, video_on, frame strobe.
// Optional VGA_SYNC_DELAY_EN: delays hsync/vsync/video_on by one more pixel tick.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic        clk,
  input  logic        rst_n,
  vga_timing_if.master vga
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

  if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX || CLK_DIV < 1) begin : g_bad_cfg
    $error("vga_timing_gen: totals must be <= %0d and CLK_DIV >= 1", COORD_MAX);
  end

  logic               pix_tick;
  logic [COORD_W-1:0] hc, vc, hc_n, vc_n;
  logic               hsync_r, vsync_r, video_on_r, frame_start_r;

  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_pix_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_tick (pix_tick)
  );

  always_comb begin
    hc_n = hc;
    vc_n = vc;
    if (pix_tick) begin
      if (hc == H_LAST) begin
        hc_n = '0;
        vc_n = (vc == V_LAST) ? '0 : vc + COORD_W'(1);
      end else begin
        hc_n = hc + COORD_W'(1);
      end
    end
  end

  // Flags decode the next-state counters so they line up with hc/vc as presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc            <= H_LAST;
      vc            <= V_LAST;
      hsync_r       <= 1'b1;
      vsync_r       <= 1'b1;
      video_on_r    <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      hc            <= hc_n;
      vc            <= vc_n;
      hsync_r       <= ~in_window(hc_n, HS_START, HS_END);
      vsync_r       <= ~in_window(vc_n, VS_START, VS_END);
      video_on_r    <= (32'(hc_n) < H_ACTIVE) && (32'(vc_n) < V_ACTIVE);
      frame_start_r <= pix_tick && (hc_n == '0) && (vc_n == '0);
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hsync_d, vsync_d, video_on_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_d    <= 1'b1;
      vsync_d    <= 1'b1;
      video_on_d <= 1'b0;
    end else if (pix_tick) begin
      hsync_d    <= hsync_r;
      vsync_d    <= vsync_r;
      video_on_d <= video_on_r;
    end
  end

  assign vga.hsync    = hsync_d;
  assign vga.vsync    = vsync_d;
  assign vga.video_on = video_on_d;
`else
  assign vga.hsync    = hsync_r;
  assign vga.vsync    = vsync_r;
  assign vga.video_on = video_on_r;
`endif

  assign vga.hc          = hc;
  assign vga.vc          = vc;
  assign vga.pix_tick    = pix_tick;
  assign vga.frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, small-raster and CLK_DIV=1 instances vs an arithmetic raster model.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_if ia();
  vga_timing_if ib();
  vga_timing_if ic();

  vga_timing_gen dut_a (.clk(clk), .rst_n(rst_n), .vga(ia));

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_b (.clk(clk), .rst_n(rst_n), .vga(ib));

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_c (.clk(clk), .rst_n(rst_n), .vga(ic));

  typedef struct {
    int cd, ha, hf, hs, hb, va, vf, vs, vb;
  } cfg_t;

  typedef struct packed {
    logic [9:0] hc;
    logic [9:0] vc;
    logic       hs, vs, von, pt, fs;
  } obs_t;

  typedef struct {
    int   n;
    int   hc, vc;
    logic hs, vs, von;
  } vec_t;

  cfg_t cfg[3];
  vec_t tbl[10];
  int   ntbl;
  int   checks = 0;
  int   errors = 0;
  int   c = -1;  // clock edges since reset release; -1 while in reset

  // Raster position after k pixel ticks since reset: tick 1 lands on 0/0.
  function automatic void raster_pos(cfg_t k, int n, output int h, output int v);
    int ht, vt, p;
    ht = k.ha + k.hf + k.hs + k.hb;
    vt = k.va + k.vf + k.vs + k.vb;
    if (n == 0) begin
      h = ht - 1;
      v = vt - 1;
    end else begin
      p = (n - 1) % (ht * vt);
      h = p % ht;
      v = p / ht;
    end
  endfunction

  function automatic obs_t model(cfg_t k, int cc);
    obs_t o;
    int   n, ks, h, v, sh, sv, ft;
    ft = (k.ha + k.hf + k.hs + k.hb) * (k.va + k.vf + k.vs + k.vb);
    n  = (cc < 0) ? 0 : cc / k.cd;
`ifdef VGA_SYNC_DELAY_EN
    ks = (n > 0) ? n - 1 : 0;
`else
    ks = n;
`endif
    raster_pos(k, n, h, v);
    raster_pos(k, ks, sh, sv);
    o.hc  = 10'(h);
    o.vc  = 10'(v);
    o.hs  = !(sh >= k.ha + k.hf && sh < k.ha + k.hf + k.hs);
    o.vs  = !(sv >= k.va + k.vf && sv < k.va + k.vf + k.vs);
    o.von = (sh < k.ha) && (sv < k.va);
    o.pt  = (cc >= 0) && ((cc % k.cd) == k.cd - 1);
    o.fs  = (cc >= 0) && (n >= 1) && (((n - 1) % ft) == 0) && ((cc % k.cd) == 0);
    return o;
  endfunction

  function automatic obs_t sample(int idx);
    obs_t s;
    case (idx)
      0: s = '{ia.hc, ia.vc, ia.hsync, ia.vsync, ia.video_on, ia.pix_tick, ia.frame_start};
      1: s = '{ib.hc, ib.vc, ib.hsync, ib.vsync, ib.video_on, ib.pix_tick, ib.frame_start};
      default: s = '{ic.hc, ic.vc, ic.hsync, ic.vsync, ic.video_on, ic.pix_tick, ic.frame_start};
    endcase
    return s;
  endfunction

  task automatic check_val(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at c=%0d: got %0d, expected %0d", name, c, act, exp);
    end
  endtask

  task automatic check_model();
    obs_t a, e;
    for (int i = 0; i < 3; i++) begin
      a = sample(i);
      e = model(cfg[i], c);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL model_dut%0d at c=%0d: got hc=%0d vc=%0d hs=%b vs=%b von=%b pt=%b fs=%b, expected hc=%0d vc=%0d hs=%b vs=%b von=%b pt=%b fs=%b",
                 i, c, a.hc, a.vc, a.hs, a.vs, a.von, a.pt, a.fs,
                 e.hc, e.vc, e.hs, e.vs, e.von, e.pt, e.fs);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rst_n) c++;
    check_model();
  endtask

  initial begin
    int t1, t2, cnt;

    cfg[0] = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
    cfg[1] = '{3, 16, 2, 4, 3, 10, 2, 2, 3};
    cfg[2] = '{1, 8, 1, 2, 1, 4, 1, 1, 1};

`ifdef VGA_SYNC_DELAY_EN
    tbl[0] = '{1,   0,   0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{2,   1,   0, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{641, 640, 0, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{642, 641, 0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{657, 656, 0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{658, 657, 0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{753, 752, 0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{754, 753, 0, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{801, 0,   1, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{802, 1,   1, 1'b1, 1'b1, 1'b1};
    ntbl = 10;
`else
    tbl[0] = '{1,   0,   0, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{640, 639, 0, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{641, 640, 0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{656, 655, 0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{657, 656, 0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{752, 751, 0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{753, 752, 0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{800, 799, 0, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{801, 0,   1, 1'b1, 1'b1, 1'b1};
    ntbl = 9;
`endif

    // Reset state held
    repeat (3) step();
    check_val("rst_hc", ia.hc, 799);
    check_val("rst_vc", ia.vc, 524);
    check_val("rst_hsync", ia.hsync, 1);
    check_val("rst_vsync", ia.vsync, 1);
    check_val("rst_video_on", ia.video_on, 0);
    check_val("rst_pix_tick_div1", ic.pix_tick, 0);

    // Release between edges; the first tick of the default build lands on edge 4
    #2 rst_n = 1'b1;
    c = 0;
    repeat (3) step();
    check_val("pre_tick_hc", ia.hc, 799);
    check_val("pre_tick_pix", ia.pix_tick, 1);
    step();
    check_val("first_hc", ia.hc, 0);
    check_val("first_vc", ia.vc, 0);
    check_val("first_frame_start", ia.frame_start, 1);
    step();
    check_val("frame_start_drop", ia.frame_start, 0);

    // Default-raster line timing checkpoints
    for (int i = 0; i < ntbl; i++) begin
      while (c < tbl[i].n * 4) step();
      check_val($sformatf("tbl%0d_hc", i), ia.hc, tbl[i].hc);
      check_val($sformatf("tbl%0d_vc", i), ia.vc, tbl[i].vc);
      check_val($sformatf("tbl%0d_hsync", i), ia.hsync, tbl[i].hs);
      check_val($sformatf("tbl%0d_vsync", i), ia.vsync, tbl[i].vs);
      check_val($sformatf("tbl%0d_video_on", i), ia.video_on, tbl[i].von);
    end

    // Frame period of the small raster: 25*17 ticks * 3 clocks
    t1 = -1; t2 = -1;
    cnt = 0;
    while (ib.frame_start !== 1'b1 && cnt < 3000) begin step(); cnt++; end
    if (ib.frame_start === 1'b1) t1 = c;
    step();
    cnt = 0;
    while (ib.frame_start !== 1'b1 && cnt < 3000) begin step(); cnt++; end
    if (ib.frame_start === 1'b1) t2 = c;
    check_val("frame_period_b", (t1 < 0 || t2 < 0) ? -1 : t2 - t1, 1275);

    // CLK_DIV=1: line period equals H_TOTAL clocks, tick held high
    t1 = -1; t2 = -1;
    cnt = 0;
    while (ic.hc !== 10'd0 && cnt < 50) begin step(); cnt++; end
    if (ic.hc === 10'd0) t1 = c;
    step();
    check_val("div1_pix_tick", ic.pix_tick, 1);
    cnt = 0;
    while (ic.hc !== 10'd0 && cnt < 50) begin step(); cnt++; end
    if (ic.hc === 10'd0) t2 = c;
    check_val("line_period_c", (t1 < 0 || t2 < 0) ? -1 : t2 - t1, 12);

    // Random mid-frame asynchronous resets; the model is compared every clock
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(200, 1500)) step();
      #2 rst_n = 1'b0;
      c = -1;
      #1 check_model();
      check_val("async_rst_hc_a", ia.hc, 799);
      repeat ($urandom_range(1, 3)) step();
      #2 rst_n = 1'b1;
      c = 0;
    end
    repeat (600) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
